// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encodings, prefix constants and event record for the PS/2 event path.
// Revision 1.0
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_CLR  = 2'd1,
    H_WAIT = 2'd2
  } hs_state_e;

  typedef enum logic [1:0] {
    A_IDLE    = 2'd0,
    A_EXT     = 2'd1,
    A_BRK     = 2'd2,
    A_EXT_BRK = 2'd3
  } asm_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

  function automatic ps2_event_t mk_event(input asm_state_e st, input logic [7:0] code);
    ps2_event_t e;
    e.brk  = (st == A_BRK) || (st == A_EXT_BRK);
    e.ext  = (st == A_EXT) || (st == A_EXT_BRK);
    e.code = code;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous show-ahead event FIFO with occupancy count and drop pulse.
// Revision 1.0
`default_nettype none

module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  ps2_event_t                 push_data_i,
  input  logic                       pop_i,
  output ps2_event_t                 rd_data_o,
  output logic                       rd_valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       drop_o
);

  localparam int AW = $clog2(DEPTH);

  ps2_event_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          w_full, w_do_push, w_do_pop;

  assign w_full    = (count_q == (AW+1)'(DEPTH));
  assign w_do_pop  = pop_i && (count_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_push = push_i && (!w_full || w_do_pop);
  assign drop_o    = push_i && w_full && !w_do_pop;

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (w_do_push && !w_do_pop)      count_q <= count_q + 1'b1;
      else if (w_do_pop && !w_do_push) count_q <= count_q - 1'b1;
    end
  end

  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

endmodule

`default_nettype wire

// File: rtl/ps2_event_ctrl.sv
// ps2_event_ctrl: decoder handshake, E0/F0 prefix assembly and host event FIFO.
// Optional prefix timeout built when PS2_EVT_TIMEOUT_EN is defined. Revision 1.0
`default_nettype none

module ps2_event_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    dec_data,
  input  logic                          dec_irq,
  output logic                          dec_int_clear,
  output logic [9:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_req,
  output logic                          irq,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clear
);

  hs_state_e  hs_q, hs_d;
  asm_state_e asm_q, asm_d;
  logic [7:0] byte_q, byte_d;
  logic       overflow_q;
  logic       w_accept, w_push, w_drop, w_tmo;
  ps2_event_t w_event, w_head;

  always_comb begin
    hs_d   = hs_q;
    byte_d = byte_q;
    case (hs_q)
      H_IDLE: if (dec_irq) begin
        hs_d   = H_CLR;
        byte_d = dec_data;
      end
      H_CLR:  hs_d = H_WAIT;
      // Wait for the decoder to drop its interrupt so one byte is never taken twice.
      H_WAIT: if (!dec_irq) hs_d = H_IDLE;
      default: hs_d = H_IDLE;
    endcase
  end

  assign w_accept      = (hs_q == H_CLR);
  assign dec_int_clear = w_accept;
  assign w_event       = mk_event(asm_q, byte_q);

  always_comb begin
    asm_d  = asm_q;
    w_push = 1'b0;
    if (w_accept) begin
      if (byte_q == PS2_PREFIX_EXT) begin
        if (asm_q == A_IDLE) asm_d = A_EXT;
      end else if (byte_q == PS2_PREFIX_BRK) begin
        if (asm_q == A_IDLE)     asm_d = A_BRK;
        else if (asm_q == A_EXT) asm_d = A_EXT_BRK;
      end else begin
        w_push = 1'b1;
        asm_d  = A_IDLE;
      end
    end else if (w_tmo) begin
      asm_d = A_IDLE;
    end
  end

`ifdef PS2_EVT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign w_tmo = (asm_q != A_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (w_accept || asm_q == A_IDLE || w_tmo) tmo_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYCLES;
  assign w_tmo      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q       <= H_IDLE;
      asm_q      <= A_IDLE;
      byte_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      hs_q   <= hs_d;
      asm_q  <= asm_d;
      byte_q <= byte_d;
      if (w_drop)         overflow_q <= 1'b1;
      else if (ovf_clear) overflow_q <= 1'b0;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_push),
    .push_data_i (w_event),
    .pop_i       (rd_req),
    .rd_data_o   (w_head),
    .rd_valid_o  (rd_valid),
    .count_o     (fifo_count),
    .drop_o      (w_drop)
  );

  assign rd_data  = w_head;
  assign irq      = rd_valid;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_event_ctrl.sv
// tb_ps2_event_ctrl: directed self-checking bench for ps2_event_ctrl.
// Revision 1.0
`default_nettype none

module tb_ps2_event_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dec_data = '0;
  logic       dec_irq = 1'b0;
  logic       dec_int_clear;
  logic [9:0] rd_data;
  logic       rd_valid;
  logic       rd_req = 1'b0;
  logic       irq;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       ovf_clear = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int clr_cnt = 0;

  ps2_event_ctrl #(
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .dec_data      (dec_data),
    .dec_irq       (dec_irq),
    .dec_int_clear (dec_int_clear),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_req        (rd_req),
    .irq           (irq),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .ovf_clear     (ovf_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dec_int_clear) clr_cnt <= clr_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise dec_irq for one byte; optionally pop in the same cycle the event is pushed.
  task automatic send_byte(input logic [7:0] b, input bit pop_with_push);
    tick();
    dec_data = b;
    dec_irq  = 1'b1;
    tick();
    check_val("clr_at_n1", {31'd0, dec_int_clear}, 32'd1);
    dec_irq = 1'b0;
    if (pop_with_push) rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
  endtask

  task automatic pop();
    tick();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    int c0;
    tick();
    tick();
    reset = 1'b0;
    check_val("rst_clear", {31'd0, dec_int_clear}, 0);
    check_val("rst_data", {22'd0, rd_data}, 0);
    check_val("rst_valid", {31'd0, rd_valid}, 0);
    check_val("rst_irq", {31'd0, irq}, 0);
    check_val("rst_count", {28'd0, fifo_count}, 0);
    check_val("rst_ovf", {31'd0, overflow}, 0);

    // Single make code
    c0 = clr_cnt;
    send_byte(8'h1C, 0);
    check_val("1c_pulses", clr_cnt - c0, 1);
    check_val("1c_data", {22'd0, rd_data}, 32'h01C);
    check_val("1c_irq", {31'd0, irq}, 1);
    pop();
    check_val("1c_pop_irq", {31'd0, irq}, 0);
    check_val("1c_pop_count", {28'd0, fifo_count}, 0);

    // Extended break sequence
    c0 = clr_cnt;
    send_byte(8'hE0, 0);
    check_val("e0_no_evt", {28'd0, fifo_count}, 0);
    send_byte(8'hF0, 0);
    check_val("f0_no_evt", {28'd0, fifo_count}, 0);
    send_byte(8'h75, 0);
    check_val("375_pulses", clr_cnt - c0, 3);
    check_val("375_data", {22'd0, rd_data}, 32'h375);
    check_val("375_count", {28'd0, fifo_count}, 1);
    pop();

    // E0 is ignored once a break prefix is pending
    send_byte(8'hF0, 0);
    send_byte(8'hE0, 0);
    send_byte(8'h1C, 0);
    check_val("f0e0_data", {22'd0, rd_data}, 32'h21C);
    pop();

    // dec_irq held high after the clear
    c0 = clr_cnt;
    tick();
    dec_data = 8'h2A;
    dec_irq  = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    dec_irq = 1'b0;
    tick();
    tick();
    check_val("hold_pulses", clr_cnt - c0, 1);
    check_val("hold_count", {28'd0, fifo_count}, 1);
    check_val("hold_data", {22'd0, rd_data}, 32'h02A);
    pop();

    // Overflow: nine pushes into eight slots
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 0);
    check_val("ovf_count", {28'd0, fifo_count}, 8);
    check_val("ovf_flag", {31'd0, overflow}, 1);
    for (int i = 0; i < 8; i++) begin
      check_val("ovf_order", {22'd0, rd_data}, 32'h010 + i);
      pop();
    end
    check_val("ovf_empty", {28'd0, fifo_count}, 0);
    check_val("ovf_sticky", {31'd0, overflow}, 1);
    pop();
    check_val("empty_pop", {28'd0, fifo_count}, 0);
    tick();
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check_val("ovf_cleared", {31'd0, overflow}, 0);

    // Full FIFO, push and pop in the same cycle
    for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i), 0);
    send_byte(8'h28, 1);
    check_val("full_pp_count", {28'd0, fifo_count}, 8);
    check_val("full_pp_ovf", {31'd0, overflow}, 0);
    check_val("full_pp_head", {22'd0, rd_data}, 32'h021);
    for (int i = 0; i < 7; i++) pop();
    check_val("full_pp_tail", {22'd0, rd_data}, 32'h028);
    pop();
    check_val("full_pp_empty", {31'd0, irq}, 0);

    // Reset after a break prefix discards it
    send_byte(8'hF0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send_byte(8'h1C, 0);
    check_val("rst_mid_data", {22'd0, rd_data}, 32'h01C);
    pop();

`ifdef PS2_EVT_TIMEOUT_EN
    send_byte(8'hE0, 0);
    for (int i = 0; i < 100; i++) tick();
    send_byte(8'h1C, 0);
    check_val("tmo_data", {22'd0, rd_data}, 32'h01C);
    pop();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_event_ctrl.md
# ps2_event_ctrl

Controller placed between `ps2_decoder` and the host bus. It runs the decoder's byte/interrupt handshake: it accepts each decoded byte and pulses `int_clear`. It folds the `E0` (extended) and `F0` (break) prefixes into complete key events and buffers those events in a small FIFO. It then presents the events to the host with a level interrupt and a pop-on-read interface.

## Interface

Parameters:
- `FIFO_DEPTH`, default 8: event FIFO depth. Must be a power of two, ≥2.
- `TIMEOUT_CYCLES`, default 50000: prefix timeout in clk cycles. Only used when `PS2_EVT_TIMEOUT_EN` is defined.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `dec_data`  in  8  decoder byte
- `dec_irq`  in  1  decoder interrupt; high while an unread byte is held
- `dec_int_clear`  out  1  one-cycle clear pulse to the decoder
- `rd_data`  out  10  head event {brk, ext, code[7:0]}, show-ahead
- `rd_valid`  out  1  FIFO not empty
- `rd_req`  in  1  pop head event; ignored when `rd_valid`=0
- `irq`  out  1  host interrupt, equal to `rd_valid`
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of events held
- `overflow`  out  1  sticky; set when an event is dropped
- `ovf_clear`  in  1  clears `overflow`

## Operation

Decoder handshake FSM (`H_IDLE`, `H_CLR`, `H_WAIT`):
- `H_IDLE`: on `dec_irq`=1, latch `dec_data` and go to `H_CLR`.
- `H_CLR`: drive `dec_int_clear`=1 for exactly this cycle, pass the latched byte to the assembler, go to `H_WAIT`.
- `H_WAIT`: stay until `dec_irq`=0, then go to `H_IDLE`. This prevents double-accepting the same byte.

Assembler FSM (`A_IDLE`, `A_EXT`, `A_BRK`, `A_EXT_BRK`), advanced once per accepted byte:
- `8'hE0`: `A_IDLE`→`A_EXT`. Ignored in any other state.
- `8'hF0`: `A_IDLE`→`A_BRK`, `A_EXT`→`A_EXT_BRK`. Ignored in `A_BRK` and `A_EXT_BRK`.
- Any other byte (including `E1`, `AA`, `FA`, `FE`, `00`, `FF`) pushes the event {brk, ext, byte}, with brk and ext taken from the current state, then returns to `A_IDLE`.

FIFO behaviour:
- Push when not full: the event is stored.
- Push when full with no simultaneous pop: the event is dropped and `overflow` is set.
- Push and pop in the same cycle when full: both succeed and `fifo_count` is unchanged.
- `rd_req` when empty: no effect.
- Pointers wrap modulo `FIFO_DEPTH`. `fifo_count` saturates at `FIFO_DEPTH`.
- `overflow` set and `ovf_clear` in the same cycle: set wins.

Reset:
- Both FSMs return to IDLE. FIFO is emptied.
- All outputs read 0: `dec_int_clear`, `rd_data`, `rd_valid`, `irq`, `fifo_count`, `overflow`.
- A reset asserted mid-sequence discards any pending prefix and any latched byte.

## Timing

- `dec_irq` rises at cycle N → `dec_int_clear`=1 at N+1 → event visible on `rd_valid` and `rd_data` at N+2.
- An accepted prefix byte produces no FIFO activity.
- A pop takes effect at the clock edge where `rd_req`=1. The next head event appears on `rd_data` in the following cycle.
- `irq` is a level signal. It goes low in the cycle after the last event is popped.
- `overflow` sets in the cycle after the dropped push.

## Configuration

- `PS2_EVT_TIMEOUT_EN` defined:
  - A counter runs while the assembler is in any non-IDLE state and restarts on each accepted byte.
  - When the counter reaches `TIMEOUT_CYCLES`, the assembler returns to `A_IDLE` and the pending prefix is discarded. No event is pushed.
- `PS2_EVT_TIMEOUT_EN` undefined: no counter is built and a prefix is held indefinitely.

## Structure

- Shared package `ps2_pkg` holds:
  - the handshake and assembler state enums;
  - the constants `PS2_PREFIX_EXT`=8'hE0 and `PS2_PREFIX_BRK`=8'hF0;
  - the packed event struct `ps2_event_t` {brk, ext, code}.
- The FIFO is one sub-module, `ps2_evt_fifo`: synchronous, show-ahead, with count output. The FSMs stay in `ps2_event_ctrl`.

## Test plan

- Byte `1C` via `dec_irq`: one `dec_int_clear` pulse; `rd_data`=10'h01C, `irq`=1; pop → `irq`=0, `fifo_count`=0.
- Bytes `E0`,`F0`,`75`: one event 10'h375; three clear pulses; no events from the prefixes.
- Hold `dec_irq` high for 5 cycles after the clear: exactly one byte accepted, one clear pulse.
- Push 9 codes with no reads (DEPTH=8): `fifo_count`=8, `overflow`=1. The first 8 codes pop in order; then `ovf_clear` → `overflow`=0.
- With a full FIFO, `rd_req` in the same cycle as a push: `fifo_count` stays 8, `overflow` stays 0.
- With `PS2_EVT_TIMEOUT_EN` and TIMEOUT_CYCLES=100: `E0`, wait 100 cycles, then `1C` → event 10'h01C (ext cleared). Reset asserted after `F0` → `1C` yields 10'h01C.
